// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_serializer
// Brief    : UART transmit frame serializer (start, 8 data LSB-first, optional
//            parity, stop). Define UART_TX_STOP2_EN for two stop bits.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_serializer (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Baud_Tick,
  input  logic [7:0] P_DATA,
  input  logic       Data_Valid,
  input  logic       Parity_Enable,
  input  logic       Parity_Type,
  input  logic       Par_Bit,
  output logic [7:0] Frame_Data,
  output logic       Frame_Par_En,
  output logic       Frame_Par_Type,
  output logic       TX_OUT,
  output logic       Busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
`ifdef UART_TX_STOP2_EN
    S_STOP   = 3'd4,
    S_STOP2  = 3'd5
`else
    S_STOP   = 3'd4
`endif
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic [2:0] r_cnt;
  logic [2:0] w_next_cnt;
  logic [7:0] r_frame_data;
  logic       r_frame_par_en;
  logic       r_frame_par_type;
  logic       r_tx;
  logic       r_busy;
  logic       w_accept;
  logic       w_frame_end;
  logic       w_tx_next;

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_accept     = 1'b0;
    w_frame_end  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Baud_Tick && Data_Valid) begin
          w_accept     = 1'b1;
          w_next_state = S_START;
        end
      end
      S_START: begin
        if (Baud_Tick) begin
          w_next_state = S_DATA;
          w_next_cnt   = 3'd0;
        end
      end
      S_DATA: begin
        if (Baud_Tick) begin
          w_next_cnt = r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            w_next_state = r_frame_par_en ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (Baud_Tick) begin
          w_next_state = S_STOP;
        end
      end
      S_STOP: begin
        if (Baud_Tick) begin
`ifdef UART_TX_STOP2_EN
          w_next_state = S_STOP2;
`else
          w_frame_end  = 1'b1;
`endif
        end
      end
`ifdef UART_TX_STOP2_EN
      S_STOP2: begin
        if (Baud_Tick) begin
          w_frame_end = 1'b1;
        end
      end
`endif
      default: w_next_state = S_IDLE;
    endcase

    // A pending request on the last stop tick chains the next frame with no idle gap
    if (w_frame_end) begin
      if (Data_Valid) begin
        w_accept     = 1'b1;
        w_next_state = S_START;
      end else begin
        w_next_state = S_IDLE;
      end
    end
  end

  always_comb begin
    w_tx_next = 1'b1;
    case (w_next_state)
      S_START:  w_tx_next = 1'b0;
      S_DATA:   w_tx_next = r_frame_data[w_next_cnt];
      S_PARITY: w_tx_next = Par_Bit;
      default:  w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state          <= S_IDLE;
      r_cnt            <= 3'd0;
      r_frame_data     <= 8'h00;
      r_frame_par_en   <= 1'b0;
      r_frame_par_type <= 1'b0;
      r_tx             <= 1'b1;
      r_busy           <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_tx    <= w_tx_next;
      r_busy  <= (w_next_state != S_IDLE);
      if (w_accept) begin
        r_frame_data     <= P_DATA;
        r_frame_par_en   <= Parity_Enable;
        r_frame_par_type <= Parity_Type;
      end
    end
  end

  assign Frame_Data     = r_frame_data;
  assign Frame_Par_En   = r_frame_par_en;
  assign Frame_Par_Type = r_frame_par_type;
  assign TX_OUT         = r_tx;
  assign Busy           = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_serializer
// Brief    : Self-checking bench for uart_tx_serializer (bit scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_serializer;

`ifdef UART_TX_STOP2_EN
  localparam int STOPS = 2;
`else
  localparam int STOPS = 1;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       Baud_Tick = 1'b0;
  logic [7:0] P_DATA = 8'h00;
  logic       Data_Valid = 1'b0;
  logic       Parity_Enable = 1'b0;
  logic       Parity_Type = 1'b0;
  logic       Par_Bit;
  logic [7:0] Frame_Data;
  logic       Frame_Par_En;
  logic       Frame_Par_Type;
  logic       TX_OUT;
  logic       Busy;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic q[$];
  logic m_t, m_r;

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       pt;
    logic       flip;
  } vec_t;
  vec_t vecs[5];

  uart_tx_serializer dut (
    .CLK(CLK), .RST(RST), .Baud_Tick(Baud_Tick), .P_DATA(P_DATA),
    .Data_Valid(Data_Valid), .Parity_Enable(Parity_Enable),
    .Parity_Type(Parity_Type), .Par_Bit(Par_Bit), .Frame_Data(Frame_Data),
    .Frame_Par_En(Frame_Par_En), .Frame_Par_Type(Frame_Par_Type),
    .TX_OUT(TX_OUT), .Busy(Busy)
  );

  // Combinational parity generator model: even -> XOR of data, odd -> inverted
  assign Par_Bit = Frame_Par_Type ? ~(^Frame_Data) : (^Frame_Data);

  always #5 CLK = ~CLK;

  initial begin
    int tdiv;
    tdiv = 0;
    forever begin
      @(negedge CLK);
      tdiv = (tdiv == 3) ? 0 : tdiv + 1;
      Baud_Tick = (tdiv == 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [7:0] d, input logic pe, input logic pt);
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(d[i]);
    if (pe) q.push_back(pt ? ~(^d) : (^d));
    for (int i = 0; i < STOPS; i++) q.push_back(1'b1);
  endtask

  // Line monitor: one bit is due after every tick edge while a frame is in progress
  initial begin
    forever begin
      @(posedge CLK);
      m_t = Baud_Tick;
      m_r = RST;
      #1;
      if (!m_r && m_t && Busy) begin
        if (q.size() == 0) check("unexpected_bit_busy", Busy, 0);
        else               check("tx_bit", TX_OUT, q.pop_front());
      end
      if (!m_r && Busy === 1'b0) check("idle_line", TX_OUT, 1);
    end
  end

  task automatic wait_accept();
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK);
      #1;
      if (Busy) return;
    end
    check("accept_timeout", Busy, 1);
  endtask

  task automatic wait_frame(input int exp_len, input logic flip);
    int   len;
    logic t;
    logic done;
    len  = 1;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge CLK);
      t = Baud_Tick;
      #1;
      if (t) begin
        if (Busy) len++;
        else      done = 1'b1;
        if (flip && len == 4) begin
          Parity_Enable = ~Parity_Enable;
          P_DATA        = ~P_DATA;
        end
      end
    end
    if (!done) check("frame_timeout", Busy, 0);
    check("frame_len", len, exp_len);
    check("queue_drained", q.size(), 0);
  endtask

  initial begin
    int   ticks;
    int   gap;
    int   L;
    logic t;

    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'h00, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'h81, 1'b1, 1'b0, 1'b1};

    repeat (3) @(negedge CLK);
    @(posedge CLK);
    #1;
    check("rst_tx", TX_OUT, 1);
    check("rst_busy", Busy, 0);
    check("rst_frame_data", Frame_Data, 8'h00);
    check("rst_par_en", Frame_Par_En, 0);
    check("rst_par_type", Frame_Par_Type, 0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (6) @(negedge CLK);

    for (int v = 0; v < 5; v++) begin
      @(negedge CLK);
      P_DATA        = vecs[v].data;
      Parity_Enable = vecs[v].pe;
      Parity_Type   = vecs[v].pt;
      push_frame(vecs[v].data, vecs[v].pe, vecs[v].pt);
      Data_Valid = 1'b1;
      wait_accept();
      check("frame_data", Frame_Data, vecs[v].data);
      check("frame_par_en", Frame_Par_En, vecs[v].pe);
      check("frame_par_type", Frame_Par_Type, vecs[v].pt);
      @(negedge CLK);
      Data_Valid = 1'b0;
      wait_frame(9 + int'(vecs[v].pe) + STOPS, vecs[v].flip);
      repeat (3) @(negedge CLK);
    end

    // Back-to-back: 0x55 then 0x0F with Data_Valid held across the frame end
    L = 9 + STOPS;
    @(negedge CLK);
    P_DATA        = 8'h55;
    Parity_Enable = 1'b0;
    push_frame(8'h55, 1'b0, 1'b0);
    push_frame(8'h0F, 1'b0, 1'b0);
    Data_Valid = 1'b1;
    wait_accept();
    @(negedge CLK);
    P_DATA = 8'h0F;
    ticks  = 1;
    gap    = 0;
    for (int i = 0; i < 400 && ticks < 2 * L + 1; i++) begin
      @(posedge CLK);
      t = Baud_Tick;
      #1;
      if (t) ticks++;
      if (ticks < 2 * L + 1 && !Busy) gap++;
      if (t && ticks == L + 1) begin
        check("b2b_second_latch", Frame_Data, 8'h0F);
        @(negedge CLK);
        Data_Valid = 1'b0;
      end
    end
    check("b2b_busy_gap", gap, 0);
    check("b2b_end_busy", Busy, 0);
    check("b2b_queue_drained", q.size(), 0);
    repeat (3) @(negedge CLK);

    // Reset in the middle of the data bits
    @(negedge CLK);
    P_DATA = 8'h3C;
    push_frame(8'h3C, 1'b0, 1'b0);
    Data_Valid = 1'b1;
    wait_accept();
    @(negedge CLK);
    Data_Valid = 1'b0;
    ticks = 0;
    for (int i = 0; i < 100 && ticks < 5; i++) begin
      @(posedge CLK);
      if (Baud_Tick) ticks++;
    end
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check("midrst_tx", TX_OUT, 1);
    check("midrst_busy", Busy, 0);
    check("midrst_frame_data", Frame_Data, 8'h00);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    q.delete();
    gap = 0;
    repeat (40) begin
      @(posedge CLK);
      #1;
      if (Busy || !TX_OUT) gap++;
    end
    check("post_reset_quiet", gap, 0);

    // Data_Valid raised just after a tick must wait for the next tick
    t = 1'b0;
    for (int i = 0; i < 20 && !t; i++) begin
      @(posedge CLK);
      t = Baud_Tick;
    end
    @(negedge CLK);
    P_DATA        = 8'hFF;
    Parity_Enable = 1'b0;
    push_frame(8'hFF, 1'b0, 1'b0);
    Data_Valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK);
      t = Baud_Tick;
      #1;
      if (!t) begin
        check("no_accept_without_tick", Busy, 0);
      end else begin
        check("accept_on_tick", Busy, 1);
        break;
      end
    end
    @(negedge CLK);
    Data_Valid = 1'b0;
    wait_frame(9 + STOPS, 1'b0);

    repeat (5) @(posedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
